// File: rtl/round_controller.sv
// round_controller: sequences one memory game round by round.
// Requests a pattern, plays the first len entries on the LEDs, scores the
// player's presses, pauses between rounds and flags game_over after the
// configured number of rounds.
module round_controller #(
  parameter int unsigned TICKS_ON      = 50,
  parameter int unsigned TICKS_GAP     = 25,
  parameter int unsigned TICKS_TERM    = 100,
  parameter int unsigned TICKS_TIMEOUT = 1000,
  parameter int unsigned NUM_ROUNDS    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  level,
  input  logic [47:0] pattern_flat,
  input  logic        pattern_ready,
  input  logic [7:0]  buttons,
  output logic        pattern_req,
  output logic [7:0]  led,
  output logic [7:0]  score,
  output logic [3:0]  round_cnt,
  output logic        last_round_ok,
  output logic        busy,
  output logic        game_over
);

  // Tick counter wide enough for the longest of the four delays.
  localparam int unsigned TMAX_A = (TICKS_ON > TICKS_GAP) ? TICKS_ON : TICKS_GAP;
  localparam int unsigned TMAX_B = (TICKS_TERM > TICKS_TIMEOUT) ? TICKS_TERM : TICKS_TIMEOUT;
  localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ON_LAST      = TW'(TICKS_ON - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(TICKS_GAP - 1);
  localparam logic [TW-1:0] TERM_LAST    = TW'(TICKS_TERM - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TICKS_TIMEOUT - 1);
  localparam logic [3:0]    ROUNDS_END   = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_PAT,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_INPUT,
    S_TERM,
    S_DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [3:0]      idx;
  logic [3:0]      len_m1;
  logic [15:0][2:0] pat;
  logic [7:0]      btn_q;

  logic            level_ok;
  logic [3:0]      level_len_m1;
  logic [7:0]      rise;
  logic [7:0]      want;
  logic [7:0]      next_show;
  logic            last_entry;
  logic [7:0]      score_inc;
  logic [3:0]      round_next;

  // Decode the one-hot level into a pattern length (minus one).
  always_comb begin
    level_ok     = 1'b0;
    level_len_m1 = 4'd0;
    case (level)
      3'b001:  begin level_ok = 1'b1; level_len_m1 = 4'd3;  end
      3'b010:  begin level_ok = 1'b1; level_len_m1 = 4'd7;  end
      3'b100:  begin level_ok = 1'b1; level_len_m1 = 4'd15; end
      default: begin level_ok = 1'b0; level_len_m1 = 4'd0;  end
    endcase
  end

  assign rise       = buttons & ~btn_q;
  assign want       = 8'd1 << pat[idx];
  assign next_show  = 8'd1 << pat[idx + 4'd1];
  assign last_entry = (idx == len_m1);
  assign score_inc  = (score == 8'hFF) ? score : score + 8'd1;
  assign round_next = round_cnt + 4'd1;

  // Game FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      timer         <= '0;
      idx           <= 4'd0;
      len_m1        <= 4'd0;
      pat           <= '0;
      btn_q         <= 8'd0;
      pattern_req   <= 1'b0;
      led           <= 8'd0;
      score         <= 8'd0;
      round_cnt     <= 4'd0;
      last_round_ok <= 1'b0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      // Delayed copy tracks buttons everywhere so presses held from playback never count.
      btn_q <= buttons;
      case (state)
        S_IDLE, S_DONE: begin
          if (start && level_ok) begin
            len_m1      <= level_len_m1;
            score       <= 8'd0;
            round_cnt   <= 4'd0;
            pattern_req <= 1'b1;
            busy        <= 1'b1;
            game_over   <= 1'b0;
            led         <= 8'd0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          pattern_req <= 1'b0;
          state       <= S_WAIT_PAT;
        end
        S_WAIT_PAT: begin
          if (pattern_ready) begin
            pat   <= pattern_flat;
            idx   <= 4'd0;
            timer <= '0;
            led   <= 8'd1 << pattern_flat[2:0];
            state <= S_SHOW_ON;
          end
        end
        S_SHOW_ON: begin
          if (timer == ON_LAST) begin
            timer <= '0;
            led   <= 8'd0;
            state <= S_SHOW_OFF;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_SHOW_OFF: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (last_entry) begin
              idx   <= 4'd0;
              led   <= buttons;
              state <= S_INPUT;
            end else begin
              idx   <= idx + 4'd1;
              led   <= next_show;
              state <= S_SHOW_ON;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_INPUT: begin
          if (rise != 8'd0) begin
            timer <= '0;
            if (rise == want) begin
              score <= score_inc;
              if (last_entry) begin
                idx           <= 4'd0;
                last_round_ok <= 1'b1;
                led           <= 8'd0;
                state         <= S_TERM;
              end else begin
                idx <= idx + 4'd1;
                led <= buttons;
              end
            end else begin
              idx           <= 4'd0;
              last_round_ok <= 1'b0;
              led           <= 8'd0;
              state         <= S_TERM;
            end
          end else if (timer == TIMEOUT_LAST) begin
            timer         <= '0;
            idx           <= 4'd0;
            last_round_ok <= 1'b0;
            led           <= 8'd0;
            state         <= S_TERM;
          end else begin
            timer <= timer + TW'(1);
            led   <= buttons;
          end
        end
        S_TERM: begin
          if (timer == TERM_LAST) begin
            timer     <= '0;
            round_cnt <= round_next;
            if (round_next == ROUNDS_END) begin
              busy      <= 1'b0;
              game_over <= 1'b1;
              led       <= 8'hFF;
              state     <= S_DONE;
            end else begin
              pattern_req <= 1'b1;
              state       <= S_REQ;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed table of rounds plus randomized rounds for
// round_controller, with expectations derived from the game rules.
module tb_round_controller;

  localparam int unsigned ON = 4, GAP = 2, TERM = 3, TIMEOUT = 20, ROUNDS = 2;

  logic        clk = 1'b0;
  logic        rst, start, pattern_ready;
  logic [2:0]  level;
  logic [47:0] pattern_flat;
  logic [7:0]  buttons;
  logic        pattern_req, last_round_ok, busy, game_over;
  logic [7:0]  led, score;
  logic [3:0]  round_cnt;

  int n_pass = 0;
  int n_total = 0;

  round_controller #(
    .TICKS_ON(ON), .TICKS_GAP(GAP), .TICKS_TERM(TERM),
    .TICKS_TIMEOUT(TIMEOUT), .NUM_ROUNDS(ROUNDS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .level(level),
    .pattern_flat(pattern_flat), .pattern_ready(pattern_ready), .buttons(buttons),
    .pattern_req(pattern_req), .led(led), .score(score), .round_cnt(round_cnt),
    .last_round_ok(last_round_ok), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  typedef struct {
    bit          st;
    logic [2:0]  lvl;
    logic [47:0] pf;
    int          kind;      // 0 all correct, 1 wrong bit, 2 timeout, 3 two bits at once
    int          k;         // correct presses before the ending event
    int          exp_score;
    bit          exp_ok;
    int          exp_rcnt;
    bit          exp_over;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic logic [7:0] oh(input logic [2:0] v);
    logic [7:0] one;
    one = 8'd1;
    return one << v;
  endfunction

  function automatic int len_of(input logic [2:0] lv);
    case (lv)
      3'b001:  return 4;
      3'b010:  return 8;
      3'b100:  return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] entry(input logic [47:0] pf, input int i);
    return pf[3*i +: 3];
  endfunction

  task automatic do_start(input string tag, input logic [2:0] lv, input bit acc, input bit prev_over);
    level = lv;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (acc) begin
      check({tag, ":pattern_req"}, int'(pattern_req), 1);
      check({tag, ":busy"}, int'(busy), 1);
      check({tag, ":game_over"}, int'(game_over), 0);
      check({tag, ":score"}, int'(score), 0);
      check({tag, ":round_cnt"}, int'(round_cnt), 0);
    end else begin
      check({tag, ":pattern_req"}, int'(pattern_req), 0);
      check({tag, ":busy"}, int'(busy), 0);
      check({tag, ":game_over"}, int'(game_over), int'(prev_over));
      check({tag, ":led"}, int'(led), prev_over ? 255 : 0);
    end
  endtask

  // Plays one round starting from the cycle where pattern_req is seen high.
  task automatic run_round(input string tag, input logic [47:0] pf, input int len,
                           input int kind, input int k, input bit held, input bit poke,
                           input int base, input int exp_score, input bit exp_ok,
                           input int exp_rcnt, input bit exp_over);
    logic [7:0] q[$];
    logic [2:0] e;
    logic [7:0] bad;
    int elapsed, exp_lat, nok;
    tick();
    check({tag, ":req_pulse"}, int'(pattern_req), 0);
    repeat ($urandom_range(0, 2)) tick();
    pattern_flat  = pf;
    pattern_ready = 1'b1;
    if (held) buttons = oh(entry(pf, 0));
    tick();
    pattern_ready = 1'b0;
    pattern_flat  = 48'({$urandom(), $urandom()});
    for (int i = 0; i < len; i++) begin
      repeat (ON) q.push_back(oh(entry(pf, i)));
      repeat (GAP) q.push_back(8'd0);
    end
    for (int s = 0; s < q.size(); s++) begin
      check({tag, ":playback"}, int'(led), int'(q[s]));
      if (poke && s == 1) begin
        start = 1'b1;
        level = 3'b100;
        pattern_ready = 1'b1;
      end
      tick();
      start = 1'b0;
      pattern_ready = 1'b0;
    end
    check({tag, ":input_entry_led"}, int'(led), held ? int'(oh(entry(pf, 0))) : 0);
    elapsed = 0;
    if (held) begin
      tick();
      check({tag, ":held_ignored"}, int'(score), base);
      buttons = 8'd0;
      tick();
    end
    nok = (kind == 0) ? len : k;
    for (int j = 0; j < nok; j++) begin
      buttons = oh(entry(pf, j));
      tick();
      buttons = 8'd0;
      elapsed = 0;
      if (kind == 0 && j == len - 1) begin
        check({tag, ":term_led"}, int'(led), 0);
      end else begin
        check({tag, ":echo"}, int'(led), int'(oh(entry(pf, j))));
        check({tag, ":running_score"}, int'(score), base + j + 1);
        tick();
        elapsed = 1;
      end
    end
    if (kind == 1 || kind == 3) begin
      e   = entry(pf, k);
      bad = oh(3'(e + 3'($urandom_range(1, 7))));
      if (kind == 3) bad = bad | oh(e);
      buttons = bad;
      tick();
      buttons = 8'd0;
      elapsed = 0;
      check({tag, ":term_led"}, int'(led), 0);
    end
    exp_lat = (kind == 2) ? int'(TIMEOUT + TERM) : int'(TERM);
    while (!(pattern_req || game_over) && elapsed < 200) begin
      tick();
      elapsed++;
    end
    check({tag, ":end_latency"}, elapsed, exp_lat);
    check({tag, ":score"}, int'(score), exp_score);
    check({tag, ":round_cnt"}, int'(round_cnt), exp_rcnt);
    check({tag, ":last_round_ok"}, int'(last_round_ok), int'(exp_ok));
    check({tag, ":game_over"}, int'(game_over), int'(exp_over));
    check({tag, ":busy"}, int'(busy), exp_over ? 0 : 1);
    check({tag, ":pattern_req"}, int'(pattern_req), exp_over ? 0 : 1);
    check({tag, ":led"}, int'(led), exp_over ? 255 : 0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [2:0] valid_lv[3];
    logic [2:0] inv_lv[5];
    logic [47:0] pf2;
    logic [2:0] lv;
    int prev, base, kind, k, gained, ns, nr;
    bit ok, ov, poke;
    int m_len, m_score, m_round;
    bit m_in_game, m_over;

    tbl[0] = '{1'b1, 3'b001, 48'h5A17_9E2D_B3C3, 0, 0, 4,  1'b1, 1, 1'b0};
    tbl[1] = '{1'b0, 3'b001, 48'h0123_4567_89AB, 2, 0, 4,  1'b0, 2, 1'b1};
    tbl[2] = '{1'b1, 3'b010, 48'hFEDC_BA98_7654, 1, 1, 1,  1'b0, 1, 1'b0};
    tbl[3] = '{1'b0, 3'b010, 48'h1357_9BDF_2468, 3, 2, 3,  1'b0, 2, 1'b1};
    tbl[4] = '{1'b1, 3'b100, 48'hC0FF_EE12_3456, 0, 0, 16, 1'b1, 1, 1'b0};
    tbl[5] = '{1'b0, 3'b100, 48'h8BAD_F00D_7E57, 2, 5, 21, 1'b0, 2, 1'b1};
    valid_lv = '{3'b001, 3'b010, 3'b100};
    inv_lv   = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    rst = 1'b1; start = 1'b0; level = 3'b000;
    pattern_flat = 48'd0; pattern_ready = 1'b0; buttons = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:pattern_req", int'(pattern_req), 0);
    check("reset:led", int'(led), 0);
    check("reset:score", int'(score), 0);
    check("reset:round_cnt", int'(round_cnt), 0);
    check("reset:last_round_ok", int'(last_round_ok), 0);
    check("reset:busy", int'(busy), 0);
    check("reset:game_over", int'(game_over), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_start("idle_bad_000", 3'b000, 1'b0, 1'b0);
    do_start("idle_bad_011", 3'b011, 1'b0, 1'b0);

    prev = 0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].st) begin
        if (i > 0) do_start("done_bad_000", 3'b000, 1'b0, 1'b1);
        do_start("tbl_start", tbl[i].lvl, 1'b1, i > 0);
      end
      base = tbl[i].st ? 0 : prev;
      run_round($sformatf("tbl%0d", i), tbl[i].pf, len_of(tbl[i].lvl), tbl[i].kind, tbl[i].k,
                1'b0, 1'b0, base, tbl[i].exp_score, tbl[i].exp_ok, tbl[i].exp_rcnt, tbl[i].exp_over);
      prev = tbl[i].exp_score;
    end

    // Button held from playback into INPUT must not score until re-pressed.
    do_start("held_start", 3'b001, 1'b1, 1'b1);
    run_round("held", 48'h0000_0000_0A4D, 4, 0, 0, 1'b1, 1'b0, 0, 4, 1'b1, 1, 1'b0);

    // Asynchronous reset in the middle of playback.
    pf2 = 48'h0000_0000_0FAC;
    tick();
    pattern_flat  = pf2;
    pattern_ready = 1'b1;
    tick();
    pattern_ready = 1'b0;
    tick();
    check("pre_rst:led", int'(led), int'(oh(entry(pf2, 0))));
    check("pre_rst:busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst:led", int'(led), 0);
    check("mid_rst:busy", int'(busy), 0);
    check("mid_rst:pattern_req", int'(pattern_req), 0);
    check("mid_rst:score", int'(score), 0);
    check("mid_rst:round_cnt", int'(round_cnt), 0);
    check("mid_rst:last_round_ok", int'(last_round_ok), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst:busy", int'(busy), 0);

    // Randomized rounds against the rule-level model.
    m_in_game = 1'b0; m_over = 1'b0; m_score = 0; m_round = 0; m_len = 0;
    for (int r = 0; r < 12; r++) begin
      if (!m_in_game) begin
        if ($urandom_range(0, 1) == 1)
          do_start("rnd_bad", inv_lv[$urandom_range(0, 4)], 1'b0, m_over);
        lv = valid_lv[$urandom_range(0, 2)];
        do_start("rnd_start", lv, 1'b1, m_over);
        m_len = len_of(lv); m_score = 0; m_round = 0; m_in_game = 1'b1;
      end
      kind = int'($urandom_range(0, 3));
      k    = int'($urandom_range(0, m_len - 1));
      poke = 1'($urandom_range(0, 1));
      gained = (kind == 0) ? m_len : k;
      ns = (m_score + gained > 255) ? 255 : m_score + gained;
      ok = (kind == 0);
      nr = m_round + 1;
      ov = (nr == int'(ROUNDS));
      run_round($sformatf("rnd%0d", r), 48'({$urandom(), $urandom()}), m_len, kind, k,
                1'b0, poke, m_score, ns, ok, nr, ov);
      m_score = ns; m_round = nr; m_over = ov; m_in_game = !ov;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
